// File: rtl/uart_rx_frame_ctrl.sv
// Framing controller after uart_rx: SYNC, LEN, LEN payload bytes, optional CSUM; payload via FIFO.
// Define UART_RX_FRAME_CSUM_EN to include the CSUM state and checksum error (code 4).
module uart_rx_frame_ctrl #(
    parameter int         CLK_HZ       = 50000000,
    parameter int         BIT_RATE     = 115200,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 64,
    parameter int         TIMEOUT_BITS = 20,
    parameter int         FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_break,
    output logic       rx_en,
    output logic       pay_valid,
    output logic [7:0] pay_data,
    output logic       pay_last,
    input  logic       pay_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic [2:0] dbg_state
);

    localparam int CYC_BIT = CLK_HZ / BIT_RATE;
    localparam int TMO     = TIMEOUT_BITS * CYC_BIT;
    localparam int TMO_W   = $clog2(TMO + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HUNT = 3'd1,
        S_LEN  = 3'd2,
`ifdef UART_RX_FRAME_CSUM_EN
        S_PAY  = 3'd3,
        S_CSUM = 3'd4
`else
        S_PAY  = 3'd3
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0]       r_remain;
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [2:0]       r_err_code;

    logic             w_in_frame;
    logic             w_byte;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_tmo;
    logic             w_len_bad;
    logic             w_last_byte;
    logic             w_ok;
    logic             w_err;
    logic [2:0]       w_code;
`ifdef UART_RX_FRAME_CSUM_EN
    logic [7:0]       r_sum;
    logic [7:0]       w_sum_next;
    assign w_sum_next = r_sum + rx_data;
`endif

    // A break in the same cycle as a strobe wins; the byte is ignored.
    assign w_in_frame  = (r_state != S_IDLE) && (r_state != S_HUNT);
    assign w_byte      = rx_valid & ~rx_break;
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_tmo       = w_in_frame & ~rx_valid & (r_tmo_cnt == TMO_W'(TMO - 1));
    assign w_len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
    assign w_last_byte = (r_remain == 8'd1);

    // Payload stream: the head transfers on a cycle where pay_valid and pay_ready
    // are both 1; head data/last hold steady while pay_valid=1 and pay_ready=0.
    assign pay_valid = (r_count != '0);
    assign w_pop     = pay_valid & pay_ready;
    assign {pay_last, pay_data} = r_mem[r_rd_ptr];

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_err || w_ok) begin
            w_next_state = ctrl_enable ? S_HUNT : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (ctrl_enable) w_next_state = S_HUNT;
                S_HUNT: begin
                    if (!ctrl_enable)                             w_next_state = S_IDLE;
                    else if (w_byte && (rx_data == SYNC_BYTE))    w_next_state = S_LEN;
                end
                S_LEN:  if (w_byte) w_next_state = S_PAY;
`ifdef UART_RX_FRAME_CSUM_EN
                S_PAY:  if (w_byte && w_last_byte) w_next_state = S_CSUM;
`endif
                default: ;
            endcase
        end
    end

    // Error decode in priority order 6 > 5 > 1 > 3 > 2 > 4.
    always_comb begin
        w_err  = 1'b0;
        w_ok   = 1'b0;
        w_code = 3'd0;
        w_push = 1'b0;
        rx_en  = (r_state != S_IDLE);
        if (w_in_frame && !ctrl_enable) begin
            w_err  = 1'b1;
            w_code = 3'd6;
        end else if ((r_state != S_IDLE) && rx_break) begin
            w_err  = 1'b1;
            w_code = 3'd5;
        end else if (w_tmo) begin
            w_err  = 1'b1;
            w_code = 3'd1;
        end else if (w_byte) begin
            case (r_state)
                S_LEN: begin
                    if (w_len_bad) begin
                        w_err  = 1'b1;
                        w_code = 3'd2;
                    end
                end
                S_PAY: begin
                    if (w_full) begin
                        w_err  = 1'b1;
                        w_code = 3'd3;
                    end else begin
                        w_push = 1'b1;
`ifndef UART_RX_FRAME_CSUM_EN
                        w_ok   = w_last_byte;
`endif
                    end
                end
`ifdef UART_RX_FRAME_CSUM_EN
                S_CSUM: begin
                    if (w_sum_next == 8'h00) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err  = 1'b1;
                        w_code = 3'd4;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_remain  <= 8'd0;
`ifdef UART_RX_FRAME_CSUM_EN
            r_sum     <= 8'd0;
`endif
        end else begin
            if (!w_in_frame || rx_valid)           r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TMO_W'(TMO))     r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if ((r_state == S_LEN) && w_byte && !w_err) begin
                r_remain <= rx_data;
`ifdef UART_RX_FRAME_CSUM_EN
                r_sum    <= rx_data;
`endif
            end else if (w_push) begin
                r_remain <= r_remain - 8'd1;
`ifdef UART_RX_FRAME_CSUM_EN
                r_sum    <= w_sum_next;
`endif
            end
        end
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 9'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_last_byte, rx_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            if (w_err)     r_err_code <= w_code;
            else if (w_ok) r_err_code <= 3'd0;
        end
    end

endmodule
